// File: rtl/noc_flit_ejector.sv
// NoC boundary ejector: accepts credit-flow-controlled flits and frames them as header/size/payload.
// Buffers framed flits and presents them on a valid/ready stream with sop/eop tags.
module noc_flit_ejector #(
   parameter int          FLIT_SIZE  = 32,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] LOCAL_ADDR = 16'h0000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   output logic                 credit_o,
   input  logic [FLIT_SIZE-1:0] data_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [FLIT_SIZE-1:0] data_o,
   output logic                 sop_o,
   output logic                 eop_o,
   output logic [31:0]          pkt_cnt_o,
   output logic                 addr_err_o,
   output logic                 busy_o
);

   localparam int ADDR_W  = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = FLIT_SIZE + 2;
   localparam logic [ADDR_W-1:0]    PTR_ONE  = 1;
   localparam logic [ADDR_W:0]      CNT_ONE  = 1;
   localparam logic [ADDR_W:0]      CNT_FULL = FIFO_DEPTH[ADDR_W:0];
   localparam logic [FLIT_SIZE-1:0] REM_ONE  = 1;

   typedef enum logic [1:0] {
      S_HEADER  = 2'd0,
      S_SIZE    = 2'd1,
      S_PAYLOAD = 2'd2
   } state_t;

   state_t                state_reg;
   logic [FLIT_SIZE-1:0]  remaining_reg;
   logic [31:0]           pkt_cnt_reg;
   logic                  addr_err_reg;

   logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]     wr_ptr_reg;
   logic [ADDR_W-1:0]     rd_ptr_reg;
   logic [ADDR_W:0]       count_reg;
   logic [ADDR_W:0]       count_next;
   logic [ENTRY_W-1:0]    head;

   logic push;
   logic pop;
   logic in_sop;
   logic in_eop;

   // Credit comes only from registered occupancy; reset just masks it.
   assign credit_o = !rst_i && (count_reg != CNT_FULL);
   assign valid_o  = (count_reg != '0);
   assign push     = rx_i && credit_o;
   assign pop      = valid_o && ready_i;

   always_comb begin
      in_sop = 1'b0;
      in_eop = 1'b0;
      case (state_reg)
         S_HEADER:  in_sop = 1'b1;
         S_SIZE:    in_eop = (data_i == '0);
         S_PAYLOAD: in_eop = (remaining_reg == REM_ONE);
         default:   in_eop = 1'b0;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + CNT_ONE;
      end else if (!push && pop) begin
         count_next = count_reg - CNT_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_reg] <= {in_sop, in_eop, data_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= S_HEADER;
         remaining_reg <= '0;
         pkt_cnt_reg   <= '0;
         addr_err_reg  <= 1'b0;
      end else if (push) begin
         case (state_reg)
            S_HEADER: begin
               if (data_i[15:0] != LOCAL_ADDR) begin
                  addr_err_reg <= 1'b1;
               end
               state_reg <= S_SIZE;
            end
            S_SIZE: begin
               remaining_reg <= data_i;
               if (data_i == '0) begin
                  pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
                  state_reg   <= S_HEADER;
               end else begin
                  state_reg <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               remaining_reg <= remaining_reg - REM_ONE;
               if (remaining_reg == REM_ONE) begin
                  pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
                  state_reg   <= S_HEADER;
               end
            end
            default: state_reg <= S_HEADER;
         endcase
      end
   end

   // Outputs are forced to zero when empty so stale RAM contents never leak out.
   assign head       = mem[rd_ptr_reg];
   assign data_o     = valid_o ? head[FLIT_SIZE-1:0] : '0;
   assign sop_o      = valid_o && head[ENTRY_W-1];
   assign eop_o      = valid_o && head[ENTRY_W-2];
   assign pkt_cnt_o  = pkt_cnt_reg;
   assign addr_err_o = addr_err_reg;
   assign busy_o     = (state_reg != S_HEADER);

endmodule
